// File: rtl/pic_fetch_unit.sv
// rtl/pic_fetch_unit.sv - PIC16 fetch stage: PC, instruction register, return stack, pipeline flushes
// Optional: define PIC_STACK_FAULT_RESET_EN to restart at address 0 on stack overflow/underflow.
module pic_fetch_unit #(
    parameter int          PC_W        = 11,
    parameter int          STACK_DEPTH = 16,
    parameter logic [13:0] NOP_WORD    = 14'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_in,
    output logic [PC_W-1:0] Rom_addr_out,
    input  logic [13:0]     Rom_data_in,
    output logic [13:0]     ir_out,
    output logic            ir_valid_out,
    output logic [PC_W-1:0] ir_pc_out,
    input  logic            branch_in,
    input  logic            call_in,
    input  logic [PC_W-1:0] branch_target_in,
    input  logic            return_in,
    input  logic            skip_in,
    output logic            stk_ovf_out,
    output logic            stk_unf_out,
    output logic [4:0]      stk_cnt_out
);

    localparam int         SP_W      = $clog2(STACK_DEPTH);
    localparam logic [4:0] DEPTH_CNT = 5'(STACK_DEPTH);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0] wrptr;
    logic [4:0]      count;

    logic            ctrl_ok;
    logic            do_ret;
    logic            do_br;
    logic            do_push;
    logic            do_skip;
    logic            stk_full;
    logic            stk_empty;
    logic            fault;
    logic [PC_W-1:0] pop_addr;
    logic [PC_W-1:0] pc_inc;

    // Control inputs refer to the word in IR, so a bubble never acts on them.
    assign ctrl_ok   = ir_valid_out & ~stall_in;
    assign do_ret    = ctrl_ok & return_in;
    assign do_br     = ctrl_ok & branch_in & ~return_in;
    assign do_push   = do_br & call_in;
    assign do_skip   = ctrl_ok & skip_in & ~return_in & ~branch_in;
    assign stk_full  = (count == DEPTH_CNT);
    assign stk_empty = (count == 5'd0);
    assign pop_addr  = stack_mem[wrptr - SP_W'(1)];
    assign pc_inc    = pc + PC_W'(1);

`ifdef PIC_STACK_FAULT_RESET_EN
    assign fault = (do_push & stk_full) | (do_ret & stk_empty);
`else
    assign fault = 1'b0;
`endif

    assign Rom_addr_out = pc;
    assign stk_cnt_out  = count;

    // Stack storage carries no reset; only the pointer and count are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[wrptr] <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= '0;
            ir_out       <= NOP_WORD;
            ir_valid_out <= 1'b0;
            ir_pc_out    <= '0;
            wrptr        <= '0;
            count        <= 5'd0;
            stk_ovf_out  <= 1'b0;
            stk_unf_out  <= 1'b0;
        end else if (!stall_in) begin
            ir_pc_out <= pc;
            if (fault) begin
                pc           <= '0;
                ir_out       <= NOP_WORD;
                ir_valid_out <= 1'b0;
                wrptr        <= '0;
                count        <= 5'd0;
                stk_ovf_out  <= stk_ovf_out | (do_push & stk_full);
                stk_unf_out  <= stk_unf_out | (do_ret & stk_empty);
            end else if (do_ret) begin
                pc           <= pop_addr;
                ir_out       <= NOP_WORD;
                ir_valid_out <= 1'b0;
                wrptr        <= wrptr - SP_W'(1);
                if (stk_empty) begin
                    stk_unf_out <= 1'b1;
                end else begin
                    count <= count - 5'd1;
                end
            end else if (do_br) begin
                pc           <= branch_target_in;
                ir_out       <= NOP_WORD;
                ir_valid_out <= 1'b0;
                if (call_in) begin
                    // A full stack wraps and silently drops its oldest return address.
                    wrptr <= wrptr + SP_W'(1);
                    if (stk_full) begin
                        stk_ovf_out <= 1'b1;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
            end else if (do_skip) begin
                pc           <= pc_inc;
                ir_out       <= NOP_WORD;
                ir_valid_out <= 1'b0;
            end else begin
                pc           <= pc_inc;
                ir_out       <= Rom_data_in;
                ir_valid_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pic_fetch_unit.sv
// tb/tb_pic_fetch_unit.sv - self-checking bench for pic_fetch_unit against a queue-based reference model
module tb_pic_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_in = 1'b0;
    logic [10:0] Rom_addr_out;
    logic [13:0] Rom_data_in;
    logic [13:0] ir_out;
    logic        ir_valid_out;
    logic [10:0] ir_pc_out;
    logic        branch_in = 1'b0;
    logic        call_in = 1'b0;
    logic [10:0] branch_target_in = '0;
    logic        return_in = 1'b0;
    logic        skip_in = 1'b0;
    logic        stk_ovf_out;
    logic        stk_unf_out;
    logic [4:0]  stk_cnt_out;

    logic [13:0] rom [0:2047];
    assign Rom_data_in = rom[Rom_addr_out];

    int passed = 0;
    int total  = 0;

    // Reference model: return stack is a bounded queue, newest entry at the back.
    int          m_pc;
    logic [13:0] m_ir;
    bit          m_valid;
    int          m_irpc;
    int          m_stk[$];
    bit          m_ovf;
    bit          m_unf;

    pic_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
        .Rom_addr_out(Rom_addr_out), .Rom_data_in(Rom_data_in),
        .ir_out(ir_out), .ir_valid_out(ir_valid_out), .ir_pc_out(ir_pc_out),
        .branch_in(branch_in), .call_in(call_in), .branch_target_in(branch_target_in),
        .return_in(return_in), .skip_in(skip_in),
        .stk_ovf_out(stk_ovf_out), .stk_unf_out(stk_unf_out), .stk_cnt_out(stk_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 0; m_ir = 14'h0000; m_valid = 0; m_irpc = 0;
        m_stk.delete(); m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step();
        int old;
        bit flush;
        bit fault;
        if (stall_in) return;
        old = m_pc; flush = 1; fault = 0;
        if (m_valid && return_in) begin
            if (m_stk.size() == 0) begin
                m_unf = 1; m_pc = 0;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else if (m_valid && branch_in) begin
            if (call_in && m_stk.size() == 16) begin
                m_ovf = 1;
`ifdef PIC_STACK_FAULT_RESET_EN
                m_stk.delete(); fault = 1;
`else
                void'(m_stk.pop_front());
`endif
            end
            if (call_in && !fault) m_stk.push_back(old);
            m_pc = fault ? 0 : int'(branch_target_in);
        end else if (m_valid && skip_in) begin
            m_pc = (old + 1) % 2048;
        end else begin
            flush = 0;
            m_ir = rom[old];
            m_pc = (old + 1) % 2048;
        end
        if (flush) m_ir = 14'h0000;
        m_valid = !flush;
        m_irpc = old;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic jump(input int target);
        branch_in = 1'b1; branch_target_in = 11'(target);
        cycle();
        branch_in = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        #2;
        total++; if (ir_valid_out !== 1'b0) $display("FAIL rst_valid: got %b want 0", ir_valid_out); else passed++;
        total++; if (ir_out !== 14'h0000) $display("FAIL rst_ir: got %h want 0000", ir_out); else passed++;
        total++; if (Rom_addr_out !== 11'h000 || ir_pc_out !== 11'h000) $display("FAIL rst_pc: addr %h irpc %h want 0", Rom_addr_out, ir_pc_out); else passed++;
        total++; if ({stk_ovf_out, stk_unf_out, stk_cnt_out} !== 7'd0) $display("FAIL rst_stack: ovf %b unf %b cnt %0d want 0", stk_ovf_out, stk_unf_out, stk_cnt_out); else passed++;
    endtask

    task automatic test_sequential();
        logic [13:0] exp_ir [3];
        exp_ir[0] = 14'h3024; exp_ir[1] = 14'h00A5; exp_ir[2] = 14'h3015;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (ir_out !== exp_ir[i] || ir_pc_out !== 11'(i) || Rom_addr_out !== 11'(i + 1) || ir_valid_out !== 1'b1)
                $display("FAIL seq_%0d: ir %h pc %h addr %h v %b want %h %h %h 1", i, ir_out, ir_pc_out, Rom_addr_out, ir_valid_out, exp_ir[i], i, i + 1);
            else passed++;
        end
    endtask

    task automatic test_branch();
        jump(12'h018);
        branch_in = 1'b1; branch_target_in = 11'h018;
        cycle();
        branch_in = 1'b0;
        total++; if (ir_valid_out !== 1'b0 || ir_out !== 14'h0000) $display("FAIL br_bubble: v %b ir %h want 0 0000", ir_valid_out, ir_out); else passed++;
        cycle();
        total++; if (ir_out !== rom[11'h018] || ir_pc_out !== 11'h018 || ir_valid_out !== 1'b1) $display("FAIL br_self: ir %h pc %h want %h 018", ir_out, ir_pc_out, rom[11'h018]); else passed++;
        total++; if (stk_cnt_out !== 5'd0) $display("FAIL br_cnt: got %0d want 0", stk_cnt_out); else passed++;
    endtask

    task automatic test_call_return();
        jump(11'h005);
        branch_in = 1'b1; call_in = 1'b1; branch_target_in = 11'h100;
        cycle();
        branch_in = 1'b0; call_in = 1'b0;
        total++; if (stk_cnt_out !== 5'd1 || ir_valid_out !== 1'b0) $display("FAIL call_cnt: cnt %0d v %b want 1 0", stk_cnt_out, ir_valid_out); else passed++;
        repeat (3) cycle();
        total++; if (ir_pc_out !== 11'h102) $display("FAIL call_run: got %h want 102", ir_pc_out); else passed++;
        return_in = 1'b1;
        cycle();
        return_in = 1'b0;
        total++; if (ir_valid_out !== 1'b0 || stk_cnt_out !== 5'd0) $display("FAIL ret_bubble: v %b cnt %0d want 0 0", ir_valid_out, stk_cnt_out); else passed++;
        cycle();
        total++; if (ir_pc_out !== 11'h006 || ir_out !== rom[6] || ir_valid_out !== 1'b1) $display("FAIL ret_target: pc %h ir %h want 006 %h", ir_pc_out, ir_out, rom[6]); else passed++;
    endtask

    task automatic test_skip_stall();
        logic [55:0] snap;
        jump(11'h007);
        skip_in = 1'b1;
        cycle();
        skip_in = 1'b0;
        total++; if (ir_valid_out !== 1'b0 || ir_pc_out !== 11'h008 || Rom_addr_out !== 11'h009) $display("FAIL skip_bubble: v %b pc %h addr %h want 0 008 009", ir_valid_out, ir_pc_out, Rom_addr_out); else passed++;
        cycle();
        total++; if (ir_pc_out !== 11'h009 || ir_out !== rom[9]) $display("FAIL skip_next: pc %h ir %h want 009 %h", ir_pc_out, ir_out, rom[9]); else passed++;
        snap = {Rom_addr_out, ir_out, ir_valid_out, ir_pc_out, stk_ovf_out, stk_unf_out, stk_cnt_out, 3'b0};
        stall_in = 1'b1; branch_in = 1'b1; branch_target_in = 11'h3FF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if ({Rom_addr_out, ir_out, ir_valid_out, ir_pc_out, stk_ovf_out, stk_unf_out, stk_cnt_out, 3'b0} !== snap)
                $display("FAIL stall_hold_%0d: addr %h ir %h pc %h want addr %h ir %h pc %h", i, Rom_addr_out, ir_out, ir_pc_out, snap[55:45], snap[44:31], snap[29:19]);
            else passed++;
        end
        stall_in = 1'b0; branch_in = 1'b0;
        cycle();
        total++; if (ir_pc_out !== 11'h00A || ir_valid_out !== 1'b1) $display("FAIL stall_resume: pc %h want 00a", ir_pc_out); else passed++;
        skip_in = 1'b1;
        cycle();
        skip_in = 1'b0; stall_in = 1'b1; return_in = 1'b1;
        repeat (2) cycle();
        total++; if (ir_valid_out !== 1'b0 || Rom_addr_out !== 11'h00C || stk_cnt_out !== 5'd0) $display("FAIL stall_bubble: v %b addr %h cnt %0d want 0 00c 0", ir_valid_out, Rom_addr_out, stk_cnt_out); else passed++;
        stall_in = 1'b0; return_in = 1'b0;
        cycle();
        total++; if (ir_pc_out !== 11'h00C || ir_valid_out !== 1'b1) $display("FAIL stall_flush_resume: pc %h v %b want 00c 1", ir_pc_out, ir_valid_out); else passed++;
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        cycle();
        jump(11'h100);
        for (int k = 1; k <= 17; k++) begin
            branch_in = 1'b1; call_in = 1'b1; branch_target_in = 11'(12'h200 + 16 * k);
            cycle();
            branch_in = 1'b0; call_in = 1'b0;
            cycle();
        end
        total++; if (stk_ovf_out !== 1'b1) $display("FAIL ovf_flag: got %b want 1", stk_ovf_out); else passed++;
`ifdef PIC_STACK_FAULT_RESET_EN
        total++; if (ir_pc_out !== 11'h000 || stk_cnt_out !== 5'd0) $display("FAIL ovf_restart: pc %h cnt %0d want 000 0", ir_pc_out, stk_cnt_out); else passed++;
        return_in = 1'b1;
        cycle();
        return_in = 1'b0;
        cycle();
        total++; if (stk_unf_out !== 1'b1 || ir_pc_out !== 11'h000) $display("FAIL unf_restart: unf %b pc %h want 1 000", stk_unf_out, ir_pc_out); else passed++;
`else
        total++; if (stk_cnt_out !== 5'd16) $display("FAIL ovf_cnt: got %0d want 16", stk_cnt_out); else passed++;
        for (int r = 1; r <= 16; r++) begin
            return_in = 1'b1;
            cycle();
            return_in = 1'b0;
            cycle();
            if (r == 1) begin
                total++; if (ir_pc_out !== 11'h301) $display("FAIL ret_first: got %h want 301", ir_pc_out); else passed++;
            end
        end
        total++; if (ir_pc_out !== 11'h211 || stk_cnt_out !== 5'd0) $display("FAIL ret_16th: pc %h cnt %0d want 211 0", ir_pc_out, stk_cnt_out); else passed++;
        total++; if (stk_unf_out !== 1'b0) $display("FAIL unf_early: got %b want 0", stk_unf_out); else passed++;
        return_in = 1'b1;
        cycle();
        return_in = 1'b0;
        total++; if (stk_unf_out !== 1'b1 || stk_cnt_out !== 5'd0) $display("FAIL unf_flag: unf %b cnt %0d want 1 0", stk_unf_out, stk_cnt_out); else passed++;
        cycle();
`endif
    endtask

    task automatic test_wrap();
        jump(11'h7FE);
        total++; if (ir_pc_out !== 11'h7FE) $display("FAIL wrap_0: got %h want 7fe", ir_pc_out); else passed++;
        cycle();
        total++; if (ir_pc_out !== 11'h7FF) $display("FAIL wrap_1: got %h want 7ff", ir_pc_out); else passed++;
        cycle();
        total++; if (ir_pc_out !== 11'h000 || Rom_addr_out !== 11'h001) $display("FAIL wrap_2: pc %h addr %h want 000 001", ir_pc_out, Rom_addr_out); else passed++;
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (Rom_addr_out !== 11'h000 || ir_out !== 14'h0000 || ir_valid_out !== 1'b0 || ir_pc_out !== 11'h000 ||
            stk_cnt_out !== 5'd0 || stk_ovf_out !== 1'b0 || stk_unf_out !== 1'b0)
            $display("FAIL async_reset: addr %h ir %h v %b pc %h cnt %0d ovf %b unf %b want all 0", Rom_addr_out, ir_out, ir_valid_out, ir_pc_out, stk_cnt_out, stk_ovf_out, stk_unf_out);
        else passed++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        cycle();
        for (int i = 0; i < 600; i++) begin
            stall_in         = ($urandom_range(0, 7) == 0);
            return_in        = (m_stk.size() > 0) && ($urandom_range(0, 9) == 0);
            branch_in        = ($urandom_range(0, 7) == 0);
            call_in          = ($urandom_range(0, 2) != 0);
            branch_target_in = 11'($urandom_range(0, 2047));
            skip_in          = ($urandom_range(0, 7) == 0);
            cycle();
            total++;
            if (ir_out !== m_ir || ir_valid_out !== m_valid || ir_pc_out !== 11'(m_irpc) || Rom_addr_out !== 11'(m_pc) ||
                stk_cnt_out !== 5'(m_stk.size()) || stk_ovf_out !== m_ovf || stk_unf_out !== m_unf) begin
                if (errs < 10)
                    $display("FAIL random_%0d: ir %h v %b pc %h addr %h cnt %0d want %h %b %h %h %0d", i, ir_out, ir_valid_out, ir_pc_out, Rom_addr_out, stk_cnt_out, m_ir, m_valid, m_irpc[10:0], m_pc[10:0], m_stk.size());
                errs++;
            end else passed++;
        end
        stall_in = 1'b0; return_in = 1'b0; branch_in = 1'b0; call_in = 1'b0; skip_in = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) rom[a] = 14'($urandom);
        rom[0] = 14'h3024; rom[1] = 14'h00A5; rom[2] = 14'h3015;
        model_reset();
        test_reset();
        test_sequential();
        test_branch();
        test_call_return();
        test_skip_stall();
        test_overflow_underflow();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pic_fetch_unit.md
Name: pic_fetch_unit

Overview:
Instruction fetch stage for the PIC16F1826-compatible core. It holds the program counter and drives the combinational program ROM address. It latches the returned 14-bit word into the instruction register for decode. It also owns the hardware return stack and applies PIC-style two-stage pipeline flushes on GOTO/CALL/RETURN and skip instructions.

Parameters:
PC_W, 11, program counter / ROM address width
STACK_DEPTH, 16, return stack entries (power of two)
NOP_WORD, 14'h0000, word inserted into IR on flush

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
stall_in  input  1  hold PC, IR, stack; all control inputs ignored while high
Rom_addr_out  output  PC_W  address to program ROM, equals PC register
Rom_data_in  input  14  ROM word for Rom_addr_out, same cycle (combinational ROM)
ir_out  output  14  instruction register to decode
ir_valid_out  output  1  0 when ir_out is a flush bubble
ir_pc_out  output  PC_W  address of instruction in ir_out
branch_in  input  1  GOTO/CALL taken: load branch_target_in
call_in  input  1  with branch_in: push return address
branch_target_in  input  PC_W  full target (decode merges PCLATH)
return_in  input  1  RETURN/RETLW/RETFIE: pop stack into PC
skip_in  input  1  skip condition true: discard next instruction
stk_ovf_out  output  1  sticky stack overflow flag
stk_unf_out  output  1  sticky stack underflow flag
stk_cnt_out  output  5  entries currently on stack (0..STACK_DEPTH)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: PC=0, ir_out=NOP_WORD, ir_valid_out=0, ir_pc_out=0, stk_cnt_out=0, flags=0, stack write pointer=0. Stack RAM contents are not reset.
- Rom_addr_out = PC register. There is no combinational path from any input to Rom_addr_out.
- Normal cycle (no stall, no control):
  - ir_out <= Rom_data_in
  - ir_pc_out <= PC
  - ir_valid_out <= 1
  - PC <= PC+1, wrapping from 2^PC_W-1 to 0.
- Fetch latency: a word appears on ir_out one edge after its address is driven.
- Control inputs describe the instruction currently in ir_out. They are honoured only when ir_valid_out=1 and stall_in=0; otherwise they are ignored.
- Priority when several are asserted: return_in > branch_in > skip_in.
- return_in:
  - PC <= stack top; count decrements.
  - ir_out <= NOP_WORD, ir_valid_out <= 0.
  - Costs 2 cycles total.
- branch_in:
  - PC <= branch_target_in.
  - IR flushed as for return.
  - If call_in is also high, push PC (address of call + 1) before the jump.
- call_in without branch_in: ignored.
- skip_in:
  - IR flushed; PC <= PC+1, so the fetched word is discarded.
  - ir_pc_out still takes the discarded address.
- Stack is circular:
  - Push at count==STACK_DEPTH: overwrites the oldest entry, count stays at STACK_DEPTH, stk_ovf_out <= 1.
  - Pop at count==0: PC takes the entry at wrptr-1 (wrapping), wrptr still decrements, count stays 0, stk_unf_out <= 1.
- Sticky flags clear only on reset.
- Stall: all registers hold, including on a stall asserted mid-flush. The bubble remains in IR.
- Reset asserted mid-operation returns every register to its reset value immediately.
- A branch to the current PC is legal and behaves identically to any other branch.

Optional Feature:
- Macro: PIC_STACK_FAULT_RESET_EN (STVREN behaviour).
- When defined: a push overflow or pop underflow forces PC <= 0, flushes IR, clears count and wrptr, and still sets the sticky flag.
- When undefined: circular wrap as described above, and execution continues.

Test Plan:
- Release reset, no control, ROM holding 0x3024@0, 0x00A5@1, 0x3015@2 -> ir_out sequence 0x3024, 0x00A5, 0x3015 on edges 1..3; ir_pc_out 0, 1, 2; Rom_addr_out 1, 2, 3.
- Branch: with IR at pc 0x018, branch_in=1, target 0x018 -> next ir_valid_out=0 with NOP; the following cycle ir_out=ROM[0x018], ir_pc_out=0x018; stk_cnt_out unchanged.
- Call/return: CALL at 0x005 to 0x100 -> stk_cnt 1, top=0x006. Later, return_in at 0x102 -> bubble, then ir_pc_out=0x006, stk_cnt 0.
- Skip, then stall: skip_in at pc 0x007 -> bubble, next ir_pc_out=0x009. Holding stall_in for 3 cycles at any point -> all outputs frozen, sequence resumes unchanged.
- Overflow/underflow:
  - 17 calls without returns -> stk_ovf_out=1, stk_cnt 16, and the 16th return yields call #2's address.
  - A return at count 0 -> stk_unf_out=1.
  - With PIC_STACK_FAULT_RESET_EN: the 17th call produces ir_pc_out=0 after the bubble.
- PC wrap and async reset: run from 0x7FE -> ir_pc_out 0x7FE, 0x7FF, 0x000. Assert rst_n low between edges -> outputs at reset values immediately, without waiting for clk.
